uart_fifo_bridge: RTL
=====================

# uart_fifo_bridge

Byte-buffering bridge between the CPU memory-mapped UART window at 0x8000_0000 and the serial UART transmitter/receiver. The address decoder produces load/store strobes for the receive register (offset 0x4) and the transmit register (offset 0x8). It reads this block's `rx_valid` and `tx_ready` as the DataOutValid/DataInReady bits of the control register (offset 0x0). Two first-word-fall-through FIFOs decouple CPU timing from UART byte timing.

## Interface
- `DEPTH`, 8, entries per FIFO; power of two, at least 2.
- `AW`, 3, pointer width; must equal log2(DEPTH).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_rd_pop`  in  1  one-cycle strobe: CPU load from offset 0x4; dequeues the RX head.
- `cpu_wr_push`  in  1  one-cycle strobe: CPU store to offset 0x8; enqueues `cpu_wdata`.
- `cpu_wdata`  in  8  byte to transmit; low byte of the store data.
- `rx_data`  out  8  RX FIFO head byte; valid only while `rx_valid` is high.
- `rx_valid`  out  1  RX FIFO not empty; maps to DataOutValid.
- `tx_ready`  out  1  TX FIFO not full; maps to DataInReady.
- `rx_count` / `tx_count`  out  AW+1  FIFO occupancy, 0..DEPTH.
- `rx_overflow` / `tx_overflow`  out  1  sticky drop flags.
- `uart_rx_data`  in  8  byte from the UART receiver.
- `uart_rx_valid`  in  1  receiver holds a byte.
- `uart_rx_ready`  out  1  bridge accepts the receiver byte; equals `!rx_full`.
- `uart_tx_data`  out  8  TX FIFO head byte.
- `uart_tx_valid`  out  1  TX FIFO not empty.
- `uart_tx_ready`  in  1  transmitter accepts a byte this cycle.

## Operation
- Each FIFO is a DEPTH×8 register array with a read pointer, a write pointer (AW bits each, wrapping DEPTH-1→0) and a count (AW+1 bits).
  - full means count==DEPTH; empty means count==0.
  - The next count is count+push-pop; it never underflows or overflows.
- RX push: occurs when `uart_rx_valid && !rx_full`.
  - The byte is written at the write pointer, and the write pointer increments.
- RX pop: occurs when `cpu_rd_pop && !rx_empty`; the read pointer increments.
  - A pop while empty is ignored; no state changes and no flag is set.
- `rx_overflow`: set when `uart_rx_valid` is high while RX is full (warns software the line is backing up). The byte is not lost; the receiver holds it until it is accepted.
- TX push: occurs when `cpu_wr_push && !tx_full`.
  - A push while full drops the byte and sets `tx_overflow`.
- TX pop: occurs when `uart_tx_valid && uart_tx_ready`.
- Overflow flags: cleared only by `rst`.
- Simultaneous push and pop on a non-empty, non-full FIFO: both take effect and the count is unchanged.
- Empty FIFO with push and pop together: only the push occurs, because the pop is qualified by empty.
- Full FIFO with push and pop together: only the pop occurs.
  - Full is evaluated from the registered count at the start of the cycle.
  - The push is refused: RX leaves `uart_rx_ready` low; TX drops the byte and sets `tx_overflow`.
- `rx_data`, `uart_tx_data`: combinational reads of the array at the read pointer (FWFT). Their value while empty is don't-care.
- Status outputs are combinational from the registered counts: `rx_valid`, `tx_ready`, `uart_tx_valid` and `uart_rx_ready`.

## Timing
- Reset: the first rising edge with `rst` high sets all pointers and counts to 0 and both overflow flags to 0.
  - From the next cycle: `rx_valid`=0, `uart_tx_valid`=0, `tx_ready`=1, `uart_rx_ready`=1.
  - Array contents are not reset.
- During `rst` high, all pushes and pops are suppressed, so reset mid-transfer discards all buffered bytes.
- Push-to-visible latency is 1 cycle. A byte accepted at edge N appears on `rx_data`/`rx_valid` (or `uart_tx_data`/`uart_tx_valid`) after edge N.
- Pop latency is 1 cycle: the next head byte is presented after the popping edge.
- The CPU load of 0x4 samples `rx_data` in the same cycle `cpu_rd_pop` is high. The decoder must therefore assert `cpu_rd_pop` only in the cycle whose data is captured.
- Throughput: 1 push and 1 pop per FIFO per cycle.

## Test plan
- Reset → `rx_count`=0, `tx_count`=0, `rx_valid`=0, `tx_ready`=1, `uart_tx_valid`=0, both flags 0.
- Write 0x41, 0x42, 0x43 with `uart_tx_ready`=0 → `tx_count`=3 and `uart_tx_data`=0x41. Then raise `uart_tx_ready` → 0x41, 0x42, 0x43 leave on consecutive cycles, after which `uart_tx_valid`=0.
- 9 CPU writes with no drain (DEPTH=8) → `tx_ready` falls after the 8th, the 9th byte is dropped, `tx_overflow`=1, `tx_count`=8.
- Receiver delivers 8 bytes 0x00..0x07, then holds 0x08 valid → `uart_rx_ready`=0 and `rx_overflow`=1. One `cpu_rd_pop` returns 0x00, then 0x08 is accepted; draining yields 0x01..0x08 in order.
- `cpu_rd_pop` on an empty RX FIFO concurrent with a receiver push of 0x55 → `rx_count`=1 and `rx_data`=0x55.
- Fill TX to 5 entries, assert `rst` for 1 cycle mid-drain → `tx_count`=0, `uart_tx_valid`=0, and no further TX handshakes.

Source files
------------

// File: rtl/uart_fifo_bridge_if.sv
// rtl/uart_fifo_bridge_if.sv - CPU/UART-side signal bundle for the UART byte-buffering bridge
interface uart_fifo_bridge_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
);
  logic          cpu_rd_pop;
  logic          cpu_wr_push;
  logic [7:0]    cpu_wdata;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          tx_ready;
  logic [AW:0]   rx_count;
  logic [AW:0]   tx_count;
  logic          rx_overflow;
  logic          tx_overflow;
  logic [7:0]    uart_rx_data;
  logic          uart_rx_valid;
  logic          uart_rx_ready;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_valid;
  logic          uart_tx_ready;

  modport master (
    output cpu_rd_pop, cpu_wr_push, cpu_wdata, uart_rx_data, uart_rx_valid, uart_tx_ready,
    input  rx_data, rx_valid, tx_ready, rx_count, tx_count, rx_overflow, tx_overflow,
           uart_rx_ready, uart_tx_data, uart_tx_valid
  );

  modport slave (
    input  cpu_rd_pop, cpu_wr_push, cpu_wdata, uart_rx_data, uart_rx_valid, uart_tx_ready,
    output rx_data, rx_valid, tx_ready, rx_count, tx_count, rx_overflow, tx_overflow,
           uart_rx_ready, uart_tx_data, uart_tx_valid
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// rtl/uart_fifo_bridge.sv - two FWFT byte FIFOs between the CPU UART window and the serial UART
module uart_fifo_bridge_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [7:0]  push_data_i,
  input  logic        pop_i,
  output logic [7:0]  head_o,
  output logic [AW:0] count_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  // Full/empty come from the registered count, so a full FIFO refuses a push even when popping.
  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

module uart_fifo_bridge #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic             clk,
  input logic             rst,
  uart_fifo_bridge_if.slave bus
);
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic rx_overflow_q, rx_overflow_d;
  logic tx_overflow_q, tx_overflow_d;

  uart_fifo_bridge_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bus.uart_rx_valid),
    .push_data_i (bus.uart_rx_data),
    .pop_i       (bus.cpu_rd_pop),
    .head_o      (bus.rx_data),
    .count_o     (bus.rx_count),
    .full_o      (rx_full),
    .empty_o     (rx_empty)
  );

  uart_fifo_bridge_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (bus.cpu_wr_push),
    .push_data_i (bus.cpu_wdata),
    .pop_i       (bus.uart_tx_ready),
    .head_o      (bus.uart_tx_data),
    .count_o     (bus.tx_count),
    .full_o      (tx_full),
    .empty_o     (tx_empty)
  );

  assign bus.rx_valid      = !rx_empty;
  assign bus.uart_rx_ready = !rx_full;
  assign bus.tx_ready      = !tx_full;
  assign bus.uart_tx_valid = !tx_empty;
  assign bus.rx_overflow   = rx_overflow_q;
  assign bus.tx_overflow   = tx_overflow_q;

  // RX overflow only warns (receiver keeps the byte); TX overflow marks a dropped CPU byte.
  assign rx_overflow_d = rx_overflow_q | (bus.uart_rx_valid & rx_full);
  assign tx_overflow_d = tx_overflow_q | (bus.cpu_wr_push & tx_full);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overflow_q <= 1'b0;
      tx_overflow_q <= 1'b0;
    end else begin
      rx_overflow_q <= rx_overflow_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end
endmodule
